// File: rtl/led_anim_pkg.sv
// Shared encodings and pattern helpers for the LED animation scheduler.
// The pass lengths and pattern tables are kept here so that the top level holds only sequencing.
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_WALK_LEFT  = 2'd0,
        MODE_WALK_RIGHT = 2'd1,
        MODE_BOUNCE     = 2'd2,
        MODE_FILL       = 2'd3
    } anim_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } anim_state_e;

    localparam logic [4:0] PASS_LEN_WALK   = 5'd8;
    localparam logic [4:0] PASS_LEN_BOUNCE = 5'd14;
    localparam logic [4:0] PASS_LEN_FILL   = 5'd16;

    function automatic logic [3:0] last_step_idx(input anim_mode_e mode);
        logic [4:0] len;
        case (mode)
            MODE_WALK_LEFT:  len = PASS_LEN_WALK;
            MODE_WALK_RIGHT: len = PASS_LEN_WALK;
            MODE_BOUNCE:     len = PASS_LEN_BOUNCE;
            MODE_FILL:       len = PASS_LEN_FILL;
            default:         len = PASS_LEN_WALK;
        endcase
        len = len - 5'd1;
        return len[3:0];
    endfunction

    // Fill relies on 8-bit wrap: 1<<8 becomes 0 so 0-1 gives 0xFF, and 0xFF<<8 gives 0x00.
    function automatic logic [7:0] anim_pattern(input anim_mode_e mode, input logic [3:0] idx);
        logic [7:0] pat;
        case (mode)
            MODE_WALK_LEFT:  pat = 8'h01 << idx[2:0];
            MODE_WALK_RIGHT: pat = 8'h80 >> idx[2:0];
            MODE_BOUNCE: begin
                if (idx < 4'd8) pat = 8'h01 << idx[2:0];
                else            pat = 8'h01 << (4'd14 - idx);
            end
            MODE_FILL: begin
                if (idx < 4'd8) pat = (8'h01 << (idx + 4'd1)) - 8'h01;
                else            pat = 8'hFF << (idx - 4'd7);
            end
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_anim_sched_tick_gen.sv
// Step prescaler: counts 0..period-1 while enabled and pulses tick on the last count.
// A period of 0 behaves as 1, so the tick then fires on every enabled cycle.
module anim_tick_gen #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count_r;
    logic [PERIOD_W-1:0] last_s;

    // Terminal count for the current period.
    always_comb begin
        last_s = {PERIOD_W{1'b0}};
        if (period == {PERIOD_W{1'b0}}) begin
            last_s = {PERIOD_W{1'b0}};
        end else begin
            last_s = period - PERIOD_W'(1);
        end
    end

    assign tick = en && (count_r == last_s);

    // Prescaler count, held at zero whenever disabled so each RUN entry starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {PERIOD_W{1'b0}};
        end else if (!en || tick) begin
            count_r <= {PERIOD_W{1'b0}};
        end else begin
            count_r <= count_r + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/led_anim_sched.sv
// LED animation scheduler: IDLE/RUN/DONE sequencer driving a registered LED pattern.
// Configuration is captured at launch; the prescaler sub-module paces pattern steps.
module led_anim_sched
    import led_anim_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [3:0]          repeat_n,
    output logic [WIDTH-1:0]    led,
    output logic                busy,
    output logic                done,
    output logic                step_tick
);

    anim_state_e         state_r, next_state_s;
    anim_mode_e          mode_r;
    logic [PERIOD_W-1:0] period_r;
    logic [3:0]          repeat_r;
    logic [3:0]          step_idx_r;
    logic [3:0]          pass_cnt_r;
    logic [WIDTH-1:0]    led_r;
    logic                tick_s;
    logic                launch_s;
    logic                last_step_s;
    logic                finish_s;
    logic [3:0]          pass_next_s;

    anim_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (state_r == ST_RUN),
        .period (period_r),
        .tick   (tick_s)
    );

    assign launch_s    = start && !stop;
    assign pass_next_s = pass_cnt_r + 4'd1;
    assign last_step_s = tick_s && (step_idx_r == last_step_idx(mode_r));
    assign finish_s    = last_step_s && (repeat_r != 4'd0) && (pass_next_s == repeat_r);

    // Next-state decode; stop always wins over start and over completion.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) next_state_s = ST_RUN;
                else          next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (stop)          next_state_s = ST_IDLE;
                else if (finish_s) next_state_s = ST_DONE;
                else               next_state_s = ST_RUN;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= next_state_s;
    end

    // Configuration capture, step/pass tracking and the registered LED pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r     <= MODE_WALK_LEFT;
            period_r   <= {PERIOD_W{1'b0}};
            repeat_r   <= 4'd0;
            step_idx_r <= 4'd0;
            pass_cnt_r <= 4'd0;
            led_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    step_idx_r <= 4'd0;
                    pass_cnt_r <= 4'd0;
                    if (launch_s) begin
                        mode_r   <= anim_mode_e'(mode);
                        period_r <= period;
                        repeat_r <= repeat_n;
                        led_r    <= anim_pattern(anim_mode_e'(mode), 4'd0);
                    end else begin
                        led_r <= {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        step_idx_r <= 4'd0;
                        pass_cnt_r <= 4'd0;
                        led_r      <= {WIDTH{1'b0}};
                    end else if (last_step_s) begin
                        step_idx_r <= 4'd0;
                        pass_cnt_r <= pass_next_s;
                        led_r      <= finish_s ? {WIDTH{1'b0}} : anim_pattern(mode_r, 4'd0);
                    end else if (tick_s) begin
                        step_idx_r <= step_idx_r + 4'd1;
                        led_r      <= anim_pattern(mode_r, step_idx_r + 4'd1);
                    end
                end
                ST_DONE: begin
                    step_idx_r <= 4'd0;
                    pass_cnt_r <= 4'd0;
                    led_r      <= {WIDTH{1'b0}};
                end
                default: begin
                    step_idx_r <= 4'd0;
                    pass_cnt_r <= 4'd0;
                    led_r      <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign led       = led_r;
    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);
    assign step_tick = tick_s;

endmodule
